// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundle of every signal between the data-memory arbiter, its two
//   requesters (port 0 = CPU load/store stage, port 1 = DMA/debug loader)
//   and the single data-memory port.
//
//   Requester handshake (both ports): the requester raises pN_req with
//   pN_we/pN_addr/pN_wdata/pN_be and holds them stable until pN_gnt is seen
//   high. The transaction is accepted on the rising edge where req and gnt
//   are both high. After that edge the fields may change freely. Keeping req
//   high asks for another transaction. pN_done pulses for one cycle when the
//   transaction completes. For loads, pN_rdata is valid in that cycle and is
//   held until the next load completes on that port.
//
//   Modports:
//     slave  - the arbiter (drives gnt/done/rdata and the memory command)
//     master - the requesters plus the memory (drive req fields and odata)
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // port 0
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [3:0]        p0_be;
  logic              p0_gnt;
  logic              p0_done;
  logic [DATA_W-1:0] p0_rdata;
  // port 1
  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic [3:0]        p1_be;
  logic              p1_gnt;
  logic              p1_done;
  logic [DATA_W-1:0] p1_rdata;
  // memory side
  logic              mem_wena;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_idata;
  logic [DATA_W-1:0] mem_odata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_be,
    output p0_gnt, p0_done, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_be,
    output p1_gnt, p1_done, p1_rdata,
    output mem_wena, mem_addr, mem_idata,
    input  mem_odata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_be,
    input  p0_gnt, p0_done, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_be,
    input  p1_gnt, p1_done, p1_rdata,
    input  mem_wena, mem_addr, mem_idata,
    output mem_odata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-requester round-robin arbiter and sequencer for the byte-addressed
//   data memory. A load takes RD then completes. A full store (be=1111) goes
//   straight to WR. A partial store reads the word in RD, merges the enabled
//   bytes, and writes the merged word back in WR. The memory reads
//   combinationally and commits writes on the falling edge of clk.
//
//   Ports:
//     clk       - system clock, all state changes on the rising edge
//     rst       - synchronous, active-high reset
//     bus       - dmem_arbiter_if.slave (both requester ports + memory port)
//     dbg_state - current FSM state (0 IDLE, 1 RD, 2 WR)
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus,
  output logic [1:0]     dbg_state
);

  localparam logic MEM_SAVE = 1'b1;
  localparam logic MEM_LOAD = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  state_t            state_q,  state_d;
  logic              last_q,   last_d;    // port granted most recently
  logic              id_q,     id_d;      // port owning the current transaction
  logic              we_q,     we_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;    // also drives mem_addr
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic [3:0]        be_q,     be_d;
  logic [DATA_W-1:0] idata_q,  idata_d;   // drives mem_idata
  logic              done0_q,  done0_d;
  logic              done1_q,  done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              gnt0, gnt1;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_be;
  logic [DATA_W-1:0] merged;

  // Round-robin grant: on a tie the port that did not win last time wins.
  // last_q resets to 1 so port 0 takes the first tie.
  always_comb begin
    gnt0 = (state_q == ST_IDLE) && !rst && bus.p0_req && (!bus.p1_req || last_q);
    gnt1 = (state_q == ST_IDLE) && !rst && bus.p1_req && (!bus.p0_req || !last_q);
  end

  // Fields of the winning requester.
  always_comb begin
    sel_we    = gnt1 ? bus.p1_we    : bus.p0_we;
    sel_addr  = gnt1 ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = gnt1 ? bus.p1_wdata : bus.p0_wdata;
    sel_be    = gnt1 ? bus.p1_be    : bus.p0_be;
  end

  // Read-modify-write merge: enabled lanes from the store data, the rest
  // from the word currently being read.
  always_comb begin
    merged = '0;
    for (int k = 0; k < 4; k++) begin
      merged[8*k +: 8] = be_q[k] ? wdata_q[8*k +: 8] : bus.mem_odata[8*k +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    idata_d  = idata_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          id_d    = gnt1;
          last_d  = gnt1;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          be_d    = sel_be;
          if (sel_we && (sel_be == 4'b1111)) begin
            // Full store needs no read; the write word is the store data.
            idata_d = sel_wdata;
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end

      ST_RD: begin
        if (!we_q) begin
          if (id_q) begin
            rdata1_d = bus.mem_odata;
            done1_d  = 1'b1;
          end else begin
            rdata0_d = bus.mem_odata;
            done0_d  = 1'b1;
          end
          state_d = ST_IDLE;
        end else begin
          idata_d = merged;
          state_d = ST_WR;
        end
      end

      ST_WR: begin
        done0_d = !id_q;
        done1_d = id_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      idata_q  <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      idata_q  <= idata_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // The write strobe is gated by rst directly so that a reset arriving
  // during WR suppresses the falling-edge commit of that same cycle.
  // A store with be=0000 walks through WR without ever writing.
  assign bus.mem_wena  = ((state_q == ST_WR) && !rst && (be_q != 4'b0000)) ? MEM_SAVE : MEM_LOAD;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_idata = idata_q;

  assign bus.p0_gnt   = gnt0;
  assign bus.p1_gnt   = gnt1;
  assign bus.p0_done  = done0_q;
  assign bus.p1_done  = done1_q;
  assign bus.p0_rdata = rdata0_q;
  assign bus.p1_rdata = rdata1_q;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam logic MEM_SAVE = 1'b1;
  localparam logic MEM_LOAD = 1'b0;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  logic [1:0] dbg_state;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- memory model ----------------
  logic [31:0] tb_mem [0:63];

  assign bus.mem_odata = tb_mem[bus.mem_addr[7:2]];

  always @(negedge clk) begin
    if (bus.mem_wena == MEM_SAVE) tb_mem[bus.mem_addr[7:2]] = bus.mem_idata;
  end

  // ---------------- scoreboard ----------------
  // exp_q entry: {port, is_load, data[31:0], done_cycle[15:0]}
  logic [49:0] exp_q[$];
  // wr_q entry: {addr[31:0], data[31:0]}
  logic [63:0] wr_q[$];
  int          gnt_port_log[$];
  int          gnt_cyc_log[$];
  int          n_checks;
  int          n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops on every done pulse and every memory write.
  always @(negedge clk) begin
    logic [49:0] e;
    logic [63:0] w;
    logic [31:0] rd;
    if (bus.p0_done || bus.p1_done) begin
      if (bus.p0_done && bus.p1_done) check("done_both", 64'(2'b11), 64'(2'b01));
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'({bus.p1_done, bus.p0_done}), 64'(0));
      end else begin
        e  = exp_q.pop_front();
        rd = bus.p1_done ? bus.p1_rdata : bus.p0_rdata;
        check("done_port", 64'(bus.p1_done), 64'(e[49]));
        check("done_cycle", 64'(cyc[15:0]), 64'(e[15:0]));
        if (e[48]) check("rdata", 64'(rd), 64'(e[47:16]));
      end
    end
    if (bus.mem_wena == MEM_SAVE) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", 64'(bus.mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        w = wr_q.pop_front();
        check("write_addr", 64'(bus.mem_addr), 64'(w[63:32]));
        check("write_data", 64'(bus.mem_idata), 64'(w[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_port(input int port, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
    if (port == 0) begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr;
      bus.p0_wdata = wdata; bus.p0_be = be;
    end else begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr;
      bus.p1_wdata = wdata; bus.p1_be = be;
    end
  endtask

  task automatic clear_req(input int port);
    if (port == 0) bus.p0_req = 1'b0;
    else           bus.p1_req = 1'b0;
  endtask

  // Call just after a rising edge. Returns just after the accept edge.
  // exp_data: load result, or the word expected on mem_idata for a store.
  task automatic issue(input int port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_data, input int lat, input bit track);
    int waited;
    int acc;
    logic g;
    waited = 0;
    set_port(port, 1'b1, we, addr, wdata, be);
    @(negedge clk);
    g = (port == 0) ? bus.p0_gnt : bus.p1_gnt;
    while (!g && waited < 40) begin
      @(negedge clk);
      waited++;
      g = (port == 0) ? bus.p0_gnt : bus.p1_gnt;
    end
    if (!g) begin
      check("grant_timeout", 64'(waited), 64'(0));
      clear_req(port);
      return;
    end
    acc = cyc + 1;
    gnt_port_log.push_back(port);
    gnt_cyc_log.push_back(acc);
    if (track) begin
      exp_q.push_back({port[0], ~we, exp_data, 16'(acc + lat)});
      if (we && be != 4'b0000) wr_q.push_back({addr, exp_data});
    end
    @(posedge clk);
    #1;
    clear_req(port);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    for (int i = 0; i < 64; i++) tb_mem[i] = 32'h0;
    tb_mem[8'h20 >> 2] = 32'h1122_3344;
    tb_mem[8'h30 >> 2] = 32'hDEAD_BEEF;

    // Reset with both ports requesting.
    rst = 1'b1;
    set_port(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'h0);
    set_port(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt",   64'({bus.p1_gnt, bus.p0_gnt}), 64'(0));
    check("rst_done",  64'({bus.p1_done, bus.p0_done}), 64'(0));
    check("rst_wena",  64'(bus.mem_wena), 64'(MEM_LOAD));
    check("rst_addr",  64'(bus.mem_addr), 64'(0));
    check("rst_idata", 64'(bus.mem_idata), 64'(0));
    check("rst_rdata0", 64'(bus.p0_rdata), 64'(0));
    check("rst_rdata1", 64'(bus.p1_rdata), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("first_tie_gnt", 64'({bus.p1_gnt, bus.p0_gnt}), 64'(2'b01));
    clear_req(0);
    clear_req(1);
    @(posedge clk);
    #1;

    // Full store then load, port 0.
    issue(0, 1'b1, 32'h10, 32'hA1B2_C3D4, 4'b1111, 32'hA1B2_C3D4, 1, 1'b1);
    issue(0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hA1B2_C3D4, 1, 1'b1);

    // Partial RMW on port 0: 0x11223344 with 0xAABBCCDD, be=0101.
    issue(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h11BB_33DD, 2, 1'b1);
    issue(0, 1'b0, 32'h20, 32'h0, 4'b0000, 32'h11BB_33DD, 1, 1'b1);

    // Partial store on port 1, top byte only, to a zero word.
    issue(1, 1'b1, 32'h40, 32'h9988_7766, 4'b1000, 32'h9900_0000, 2, 1'b1);
    issue(1, 1'b0, 32'h40, 32'h0, 4'b0000, 32'h9900_0000, 1, 1'b1);

    // Store with be=0000: no write, done still pulses.
    issue(0, 1'b1, 32'h30, 32'h0102_0304, 4'b0000, 32'h0, 2, 1'b1);
    repeat (4) @(posedge clk);
    check("be0_mem", 64'(tb_mem[8'h30 >> 2]), 64'(32'hDEAD_BEEF));
    #1;
    issue(1, 1'b0, 32'h30, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1, 1'b1);

    // Contention: both ports keep requesting loads.
    repeat (3) @(posedge clk);
    #1;
    gnt_port_log.delete();
    gnt_cyc_log.delete();
    fork
      begin
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hA1B2_C3D4, 1, 1'b1);
        issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 1, 1'b1);
        issue(0, 1'b0, 32'h00, 32'h0, 4'h0, 32'h0000_0000, 1, 1'b1);
      end
      begin
        issue(1, 1'b0, 32'h30, 32'h0, 4'h0, 32'hDEAD_BEEF, 1, 1'b1);
        issue(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'h9900_0000, 1, 1'b1);
        issue(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hA1B2_C3D4, 1, 1'b1);
      end
    join
    check("cont_count", 64'(gnt_port_log.size()), 64'(6));
    if (gnt_port_log.size() == 6) begin
      check("cont_first", 64'(gnt_port_log[0]), 64'(0));
      for (int i = 1; i < 6; i++) begin
        check("cont_alt_port", 64'(gnt_port_log[i]), 64'(1 - gnt_port_log[i-1]));
        check("cont_spacing", 64'(gnt_cyc_log[i] - gnt_cyc_log[i-1]), 64'(2));
      end
    end

    // Reset during WR of a port 1 full store.
    repeat (3) @(posedge clk);
    #1;
    issue(1, 1'b1, 32'h44, 32'h1234_5678, 4'b1111, 32'h1234_5678, 1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rstwr_wena", 64'(bus.mem_wena), 64'(MEM_LOAD));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstwr_state", 64'(dbg_state), 64'(0));
    check("rstwr_done", 64'(bus.p1_done), 64'(0));
    repeat (3) @(posedge clk);
    check("rstwr_mem", 64'(tb_mem[8'h44 >> 2]), 64'(0));
    #1;
    issue(1, 1'b0, 32'h44, 32'h0, 4'h0, 32'h0000_0000, 1, 1'b1);

    // Drain and confirm every expectation was consumed.
    repeat (6) @(posedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    check("wr_q_empty", 64'(wr_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the byte-addressed data memory. It sits between the CPU load/store stage (port 0) and the DMA/debug loader (port 1) on one side, and the single data memory port (`wena`, `addr`, `idata`, `odata`) on the other. It grants requests round-robin, sequences load and store cycles, and turns partial-word stores into read-modify-write pairs. The data memory writes on the falling edge of `clk` and reads combinationally.

## Interface
- `ADDR_W`, 32, byte address width (matches `MemAddrBus`)
- `DATA_W`, 32, data word width (matches `MemBus`); fixed at 4 byte lanes

- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `pN_req`  in  1  port N (N=0,1) request valid
- `pN_we`  in  1  1 = store, 0 = load
- `pN_addr`  in  ADDR_W  byte address; lanes cover addr..addr+3
- `pN_wdata`  in  DATA_W  store data, little-endian lanes
- `pN_be`  in  4  byte enables; store only, ignored on load
- `pN_gnt`  out  1  combinational accept; transaction captured at this rising edge
- `pN_done`  out  1  registered one-cycle completion pulse
- `pN_rdata`  out  DATA_W  load result; valid while `pN_done`=1, held until next load done on that port
- `mem_wena`  out  1  memory write enable: `MemSave` or `MemLoad`
- `mem_addr`  out  ADDR_W  memory address
- `mem_idata`  out  DATA_W  memory write data
- `mem_odata`  in  DATA_W  memory read data (combinational)

## Operation
- States: IDLE, RD, WR.
- IDLE accept:
  - When `rst`=0 and any `req` is high, exactly one `gnt` is high.
  - Capture id, we, addr, wdata and be.
  - Load → RD. Store with be=1111 → WR. Store with any other be → RD.
- Arbitration:
  - A single requester wins.
  - If both request, the port not granted last wins.
  - The `last` pointer resets to 1, so port 0 wins the first tie.
  - `last` updates only on accept.
- RD:
  - Drive `mem_addr` = captured addr and `mem_wena` = `MemLoad`.
  - At the rising edge, capture `mem_odata`.
  - Load: load `pN_rdata`, pulse `pN_done`, go to IDLE.
  - Partial store: go to WR.
- WR:
  - Drive `mem_wena` = `MemSave` and `mem_addr` = addr.
  - `mem_idata` byte k = be[k] ? wdata byte k : captured read byte k. For full stores, `mem_idata` = wdata.
  - The memory commits at the falling edge inside WR.
  - Rising edge: pulse `pN_done`, go to IDLE.
- Store with be=0000: passes RD → WR with `mem_wena` held at `MemLoad`. No write occurs and `done` still pulses.
- Outside WR, `mem_wena` = `MemLoad`. `mem_addr` and `mem_idata` hold their last values.
- The address is forwarded unmodified. No alignment check; range and wrap behaviour belong to the memory.
- `gnt` is 0 in RD and WR. A request arriving then waits, held by the requester, until IDLE.

## Timing
- Reset values: state IDLE, `last`=1, all `gnt`/`done` 0, all `rdata` 0, `mem_wena` = `MemLoad`, `mem_addr` 0, `mem_idata` 0.
- `mem_wena` = `MemSave` only when state=WR and `rst`=0. Reset asserted during WR therefore suppresses that cycle's write.
- Reset mid-transaction: return to IDLE, no `done`, memory unchanged.
- Latency from the accept edge t0 to the done cycle:
  - Load: done at t1.
  - Full store: done at t1.
  - Partial store: done at t2.
- `done` is high in the cycle after completion, which is an IDLE cycle. A new accept may occur in that same cycle.
- Throughput: one load or full store per 2 cycles; one partial store per 3 cycles.
- Requester rules:
  - Hold `req`/`we`/`addr`/`wdata`/`be` stable until `gnt`.
  - After `gnt`, the fields may change freely.
  - Keeping `req` high requests a new transaction.

## Test plan
- Reset: hold `rst` 2 cycles with both `req`=1 → `gnt`=00, `done`=00, `mem_wena` = `MemLoad`. After release, port 0 is granted first.
- Full store then load, port 0: store addr 0x10, data 0xA1B2C3D4, be=1111; done 1 cycle after accept. Then load 0x10 → `p0_rdata` = 0xA1B2C3D4 with `done`, 1 cycle after accept.
- Partial RMW: memory 0x20 = 0x11223344; store wdata 0xAABBCCDD, be=0101 → `mem_idata` = 0x11BB33DD in WR, done 2 cycles after accept, reload returns 0x11BB33DD.
- Contention: both ports `req` continuously with loads → grants alternate 0,1,0,1 every 2 cycles, each `done` matches its port's address, and no starvation.
- be=0000 store to 0x30 (holding 0xDEADBEEF) → `mem_wena` never `MemSave`, `done` pulses, memory still 0xDEADBEEF.
- `rst` asserted in WR of a port 1 store → no `MemSave` cycle, no `p1_done`, target word unchanged, state IDLE.
